// File: rtl/hp2_transfer_sequencer_if.sv
// DMA command channel between the HP2 transfer sequencer (master) and the DMA engine (slave).
interface hp2_transfer_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [16:0]       cmd_len;
    logic              cmd_done;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  cmd_ready, cmd_done
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        output cmd_ready, cmd_done
    );
endinterface

// File: rtl/hp2_transfer_sequencer.sv
// Per-layer HP2 DMA sequencer: bias read, weight read, compute, OFM write, split into <=MAX_CHUNK commands.
// First cmd_valid 1 cycle after start; payload held under cmd_ready=0; one command outstanding until cmd_done.
module hp2_transfer_sequencer #(
    parameter int MAX_CHUNK = 4096,
    parameter int ADDR_W    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     hp2_ap_start,
    input  logic                     en_bias,
    input  logic [31:0]              bias_transferbyte,
    input  logic [31:0]              weight_transferbyte,
    input  logic [31:0]              ofm_transferbyte,
    input  logic [ADDR_W-1:0]        bias_base,
    input  logic [ADDR_W-1:0]        weight_base,
    input  logic [ADDR_W-1:0]        ofm_base,
    hp2_transfer_sequencer_if.master cmd,
    output logic                     compute_start,
    input  logic                     compute_done,
    output logic                     busy,
    output logic                     layer_done
);

    typedef enum logic [3:0] {
        IDLE, BIAS_CMD, BIAS_WAIT, WGT_CMD, WGT_WAIT,
        COMP_START, COMP_WAIT, OFM_CMD, OFM_WAIT, DONE
    } state_t;

    state_t            state, state_n;
    logic [31:0]       rem, rem_n;
    logic [ADDR_W-1:0] cur_addr, addr_n;

    // Later segments are captured at start so port changes mid-layer are harmless.
    logic [31:0]       wgt_bytes_q, ofm_bytes_q;
    logic [ADDR_W-1:0] wgt_base_q, ofm_base_q;

    function automatic logic is_cmd(input state_t s);
        return (s == BIAS_CMD) || (s == WGT_CMD) || (s == OFM_CMD);
    endfunction

    function automatic logic [16:0] chunk(input logic [31:0] r);
        return (r >= 32'(MAX_CHUNK)) ? 17'(MAX_CHUNK) : r[16:0];
    endfunction

    always_comb begin
        state_n = state;
        rem_n   = rem;
        addr_n  = cur_addr;
        case (state)
            IDLE: begin
                if (hp2_ap_start) begin
                    if (en_bias && (bias_transferbyte != 32'd0)) begin
                        state_n = BIAS_CMD;
                        rem_n   = bias_transferbyte;
                        addr_n  = bias_base;
                    end else if (weight_transferbyte != 32'd0) begin
                        state_n = WGT_CMD;
                        rem_n   = weight_transferbyte;
                        addr_n  = weight_base;
                    end else begin
                        state_n = COMP_START;
                    end
                end
            end
            BIAS_CMD: if (cmd.cmd_ready) state_n = BIAS_WAIT;
            BIAS_WAIT: begin
                if (cmd.cmd_done) begin
                    if (rem != 32'd0) begin
                        state_n = BIAS_CMD;
                    end else if (wgt_bytes_q != 32'd0) begin
                        state_n = WGT_CMD;
                        rem_n   = wgt_bytes_q;
                        addr_n  = wgt_base_q;
                    end else begin
                        state_n = COMP_START;
                    end
                end
            end
            WGT_CMD: if (cmd.cmd_ready) state_n = WGT_WAIT;
            WGT_WAIT: begin
                if (cmd.cmd_done) state_n = (rem != 32'd0) ? WGT_CMD : COMP_START;
            end
            COMP_START: state_n = COMP_WAIT;
            COMP_WAIT: begin
                if (compute_done) begin
                    if (ofm_bytes_q != 32'd0) begin
                        state_n = OFM_CMD;
                        rem_n   = ofm_bytes_q;
                        addr_n  = ofm_base_q;
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            OFM_CMD: if (cmd.cmd_ready) state_n = OFM_WAIT;
            OFM_WAIT: begin
                if (cmd.cmd_done) state_n = (rem != 32'd0) ? OFM_CMD : DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // Accepted command: advance the working window by the length just issued.
        if (is_cmd(state) && cmd.cmd_ready) begin
            rem_n  = rem - 32'(cmd.cmd_len);
            addr_n = cur_addr + ADDR_W'(cmd.cmd_len);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            rem           <= '0;
            cur_addr      <= '0;
            wgt_bytes_q   <= '0;
            ofm_bytes_q   <= '0;
            wgt_base_q    <= '0;
            ofm_base_q    <= '0;
            cmd.cmd_valid <= 1'b0;
            cmd.cmd_write <= 1'b0;
            cmd.cmd_addr  <= '0;
            cmd.cmd_len   <= '0;
            compute_start <= 1'b0;
            busy          <= 1'b0;
            layer_done    <= 1'b0;
        end else begin
            state    <= state_n;
            rem      <= rem_n;
            cur_addr <= addr_n;
            if (state == IDLE && hp2_ap_start) begin
                wgt_bytes_q <= weight_transferbyte;
                ofm_bytes_q <= ofm_transferbyte;
                wgt_base_q  <= weight_base;
                ofm_base_q  <= ofm_base;
            end
            cmd.cmd_valid <= is_cmd(state_n);
            cmd.cmd_write <= (state_n == OFM_CMD);
            cmd.cmd_addr  <= is_cmd(state_n) ? addr_n : '0;
            cmd.cmd_len   <= is_cmd(state_n) ? chunk(rem_n) : '0;
            compute_start <= (state_n == COMP_START);
            busy          <= (state_n != IDLE);
            layer_done    <= (state_n == DONE);
        end
    end

endmodule

// File: tb/tb_hp2_transfer_sequencer.sv
// Scoreboard bench for hp2_transfer_sequencer: stimulus pushes expected events, a monitor pops them.
module tb_hp2_transfer_sequencer;
    localparam int ADDR_W = 32;

    logic clk;
    logic rst_n, start, en_bias;
    logic [31:0] bias_b, wgt_b, ofm_b;
    logic [31:0] bias_a, wgt_a, ofm_a;
    logic cmd_ready_r, dma_done, stray_cmd_done, comp_done, stray_comp_done;
    logic compute_start, compute_done, busy, layer_done;

    hp2_transfer_sequencer_if #(.ADDR_W(ADDR_W)) bus ();
    assign bus.cmd_ready = cmd_ready_r;
    assign bus.cmd_done  = dma_done | stray_cmd_done;
    assign compute_done  = comp_done | stray_comp_done;

    hp2_transfer_sequencer #(.MAX_CHUNK(4096), .ADDR_W(ADDR_W)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .hp2_ap_start        (start),
        .en_bias             (en_bias),
        .bias_transferbyte   (bias_b),
        .weight_transferbyte (wgt_b),
        .ofm_transferbyte    (ofm_b),
        .bias_base           (bias_a),
        .weight_base         (wgt_a),
        .ofm_base            (ofm_a),
        .cmd                 (bus),
        .compute_start       (compute_start),
        .compute_done        (compute_done),
        .busy                (busy),
        .layer_done          (layer_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // kind: 0 = command handshake, 1 = compute_start, 2 = layer_done
    typedef struct {
        int          kind;
        logic        wr;
        logic [31:0] addr;
        logic [16:0] len;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic push_cmd(input logic wr, input logic [31:0] addr, input logic [16:0] len);
        ev_t e;
        e.kind = 0; e.wr = wr; e.addr = addr; e.len = len;
        exp_q.push_back(e);
    endtask

    task automatic push_ev(input int kind);
        ev_t e;
        e.kind = kind; e.wr = 1'b0; e.addr = 32'd0; e.len = 17'd0;
        exp_q.push_back(e);
    endtask

    task automatic check_event(input int kind, input logic wr, input logic [31:0] addr,
                               input logic [16:0] len);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event actual kind=%0d wr=%0b addr=0x%0h len=%0d required none",
                     kind, wr, addr, len);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || (kind == 0 && (e.wr !== wr || e.addr !== addr || e.len !== len))) begin
                errors++;
                $display("FAIL event actual kind=%0d wr=%0b addr=0x%0h len=%0d required kind=%0d wr=%0b addr=0x%0h len=%0d",
                         kind, wr, addr, len, e.kind, e.wr, e.addr, e.len);
            end
        end
    endtask

    // Monitor: every observable output event is matched against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.cmd_valid && cmd_ready_r)
                    check_event(0, bus.cmd_write, bus.cmd_addr, bus.cmd_len);
                if (compute_start) check_event(1, 1'b0, 32'd0, 17'd0);
                if (layer_done)    check_event(2, 1'b0, 32'd0, 17'd0);
            end
        end
    end

    // DMA model: completion pulse sampled 3 cycles after each accepted command.
    initial begin
        dma_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.cmd_valid && cmd_ready_r) begin
                repeat (3) @(posedge clk);
                #1 dma_done = 1'b1;
                @(posedge clk);
                #1 dma_done = 1'b0;
            end
        end
    end

    // Compute model: done pulse a few cycles after compute_start.
    initial begin
        comp_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && compute_start) begin
                repeat (4) @(posedge clk);
                #1 comp_done = 1'b1;
                @(posedge clk);
                #1 comp_done = 1'b0;
            end
        end
    end

    task automatic cfg(input logic eb, input logic [31:0] bb, input logic [31:0] ba,
                       input logic [31:0] wb, input logic [31:0] wa,
                       input logic [31:0] ob, input logic [31:0] oa);
        en_bias = eb; bias_b = bb; bias_a = ba;
        wgt_b = wb; wgt_a = wa; ofm_b = ob; ofm_a = oa;
    endtask

    task automatic cfg_s1();
        cfg(1'b1, 32'd64, 32'h1000, 32'd9216, 32'h2000, 32'd2048, 32'h8000);
    endtask

    task automatic push_s1_reads();
        push_cmd(1'b0, 32'h1000, 17'd64);
        push_cmd(1'b0, 32'h2000, 17'd4096);
        push_cmd(1'b0, 32'h3000, 17'd4096);
        push_cmd(1'b0, 32'h4000, 17'd1024);
        push_ev(1);
    endtask

    task automatic push_s1();
        push_s1_reads();
        push_cmd(1'b1, 32'h8000, 17'd2048);
        push_ev(2);
    endtask

    // Pulse start, then scramble every config input to prove they were captured.
    task automatic start_layer();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        en_bias = ~en_bias;
        bias_b = 32'd12; wgt_b = 32'h0007_7777; ofm_b = 32'd1;
        bias_a = 32'hDEAD_0000; wgt_a = 32'hBEEF_0000; ofm_a = 32'hCAFE_0000;
    endtask

    task automatic wait_cmd(input string name, input logic [31:0] addr);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            @(negedge clk);
            if (bus.cmd_valid && bus.cmd_addr == addr) found = 1'b1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=no command required addr=0x%0h", name, addr);
        end
    endtask

    task automatic wait_layer_done(input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (layer_done) found = 1'b1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL %s_layer_done_timeout actual=none required=pulse", name);
        end
        repeat (3) @(negedge clk);
        check_val({name, "_queue_empty"}, exp_q.size(), 32'd0);
        check_val({name, "_idle_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=no finish required=finish");
        $fatal(1);
    end

    initial begin
        bit found;
        rst_n = 1'b0; start = 1'b0; cmd_ready_r = 1'b1;
        stray_cmd_done = 1'b0; stray_comp_done = 1'b0;
        cfg(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_cmd_valid", {31'd0, bus.cmd_valid}, 32'd0);
        check_val("rst_cmd_write", {31'd0, bus.cmd_write}, 32'd0);
        check_val("rst_cmd_addr", bus.cmd_addr, 32'd0);
        check_val("rst_cmd_len", {15'd0, bus.cmd_len}, 32'd0);
        check_val("rst_compute_start", {31'd0, compute_start}, 32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_layer_done", {31'd0, layer_done}, 32'd0);

        // 1: full layer, first command one cycle after start
        cfg_s1();
        push_s1();
        start_layer();
        @(negedge clk);
        check_val("s1_first_valid", {31'd0, bus.cmd_valid}, 32'd1);
        check_val("s1_first_addr", bus.cmd_addr, 32'h1000);
        check_val("s1_busy", {31'd0, busy}, 32'd1);
        wait_layer_done("s1");

        // 2: long OFM segment split into 35 full chunks and a 296 B tail
        cfg(1'b0, 32'd64, 32'h1000, 32'd256, 32'h2000, 32'd143656, 32'h0001_0000);
        push_cmd(1'b0, 32'h2000, 17'd256);
        push_ev(1);
        for (int i = 0; i < 35; i++) push_cmd(1'b1, 32'h0001_0000 + 32'(i) * 32'h1000, 17'd4096);
        push_cmd(1'b1, 32'h0003_3000, 17'd296);
        push_ev(2);
        start_layer();
        wait_layer_done("s2");

        // 3: maxpool layer, no reads, compute starts right away
        cfg(1'b0, 32'd64, 32'h1000, 32'd0, 32'h2000, 32'd2048, 32'h8000);
        push_ev(1);
        push_cmd(1'b1, 32'h8000, 17'd2048);
        push_ev(2);
        start_layer();
        @(negedge clk);
        check_val("s3_compute_start_latency", {31'd0, compute_start}, 32'd1);
        check_val("s3_no_cmd", {31'd0, bus.cmd_valid}, 32'd0);
        wait_layer_done("s3");

        // 4: backpressure on the second weight command
        cfg_s1();
        push_s1();
        start_layer();
        wait_cmd("s4_w1", 32'h2000);
        @(posedge clk);
        #1 cmd_ready_r = 1'b0;
        wait_cmd("s4_w2", 32'h3000);
        for (int k = 0; k < 5; k++) begin
            if (k != 0) @(negedge clk);
            check_val("s4_stall_valid", {31'd0, bus.cmd_valid}, 32'd1);
            check_val("s4_stall_addr", bus.cmd_addr, 32'h3000);
            check_val("s4_stall_len", {15'd0, bus.cmd_len}, 32'd4096);
        end
        @(posedge clk);
        #1 cmd_ready_r = 1'b1;
        wait_layer_done("s4");

        // 5: start while busy, stray completions in COMP_START and IDLE
        cfg_s1();
        push_s1();
        start_layer();
        wait_cmd("s5_w1", 32'h2000);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            @(negedge clk);
            if (compute_start) found = 1'b1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL s5_compute_start_timeout actual=none required=pulse");
        end
        #1 stray_cmd_done = 1'b1; stray_comp_done = 1'b1;
        @(posedge clk);
        #1 stray_cmd_done = 1'b0; stray_comp_done = 1'b0;
        wait_layer_done("s5");
        @(posedge clk);
        #1 stray_cmd_done = 1'b1; stray_comp_done = 1'b1;
        @(posedge clk);
        #1 stray_cmd_done = 1'b0; stray_comp_done = 1'b0;
        repeat (4) @(negedge clk);
        check_val("s5_idle_busy", {31'd0, busy}, 32'd0);
        check_val("s5_idle_valid", {31'd0, bus.cmd_valid}, 32'd0);

        // 6: reset in OFM_WAIT, then an identical replay of the first layer
        cfg_s1();
        push_s1_reads();
        push_cmd(1'b1, 32'h8000, 17'd2048);
        start_layer();
        wait_cmd("s6_ofm", 32'h8000);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_val("s6_rst_busy", {31'd0, busy}, 32'd0);
        check_val("s6_rst_valid", {31'd0, bus.cmd_valid}, 32'd0);
        repeat (6) @(negedge clk);
        check_val("s6_no_layer_done", exp_q.size(), 32'd0);
        check_val("s6_idle_after_rst", {31'd0, busy}, 32'd0);
        cfg_s1();
        push_s1();
        start_layer();
        wait_layer_done("s6_replay");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
